// File: rtl/wb_target_arb_rr.sv
// wb_target_arb_rr: per-target round-robin Wishbone arbiter with bus-cycle lock and stall watchdog
module wb_target_arb_rr #(
   parameter int N_REQ = 4,
   parameter int TIMEOUT = 256,
   localparam int ID_BITS = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   cyc,
   input  logic               tack,
   input  logic               terr,
   output logic [N_REQ-1:0]   gnt,
   output logic [ID_BITS-1:0] gnt_id,
   output logic               gnt_valid,
   output logic               to_err
);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d, cand;
   logic [ID_BITS-1:0] id_q, id_d, last_q, last_d, sel;
   logic valid_q, sel_ok, own_cyc, own_req, arb;
   assign own_cyc = |(cyc & gnt_q);
   assign own_req = |(req & gnt_q);
   assign arb = (state_q == IDLE) | ~own_cyc;
   assign cand = (state_q == IDLE) ? req : req & ~gnt_q;
   // first candidate at or after last_q+1, wrapping; the released owner is already masked out
   always_comb begin
      int j;
      j = 0;
      sel_ok = 1'b0;
      sel = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         j = int'(last_q) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!sel_ok && cand[ID_BITS'(j)]) begin
            sel_ok = 1'b1;
            sel = ID_BITS'(j);
         end
      end
   end
   // grant moves only at an arbitration point: idle, or the owner dropped cyc
   always_comb begin
      state_d = state_q;
      gnt_d = gnt_q;
      id_d = id_q;
      last_d = last_q;
      if (arb) begin
         state_d = sel_ok ? BUSY : IDLE;
         gnt_d = sel_ok ? N_REQ'(1) << sel : '0;
         if (sel_ok) begin
            id_d = sel;
            last_d = sel;
         end
      end
   end
   // arbitration state; last_q starts at the top index so initiator 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q <= '0;
         id_q <= '0;
         last_q <= ID_BITS'(N_REQ - 1);
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q <= gnt_d;
         id_q <= id_d;
         last_q <= last_d;
         valid_q <= |gnt_d;
      end
   end
   assign gnt = gnt_q;
   assign gnt_id = id_q;
   assign gnt_valid = valid_q;
   if (TIMEOUT > 0) begin : g_wd
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic stall, hit;
      assign stall = (state_q == BUSY) & own_cyc & own_req & ~tack & ~terr;
      assign hit = stall & (cnt_q == CNT_W'(TIMEOUT - 1));
      assign cnt_d = (stall & ~hit) ? cnt_q + 1'b1 : '0;
      // stall counter; a same-cycle ack or err suppresses the pulse
      always_ff @(posedge clk or posedge rst) begin
         if (rst) cnt_q <= '0;
         else cnt_q <= cnt_d;
      end
      assign to_err = hit;
   end else begin : g_nowd
      assign to_err = 1'b0;
   end
endmodule

// File: tb/tb_wb_target_arb_rr.sv
// tb_wb_target_arb_rr: directed checks of grant, lock, rotation, watchdog and async reset
module tb_wb_target_arb_rr;
   logic clk, rst, tack, terr, gnt_valid, to_err;
   logic [3:0] req, cyc, gnt, oh;
   logic [1:0] gnt_id;
   int total = 0;
   int bad = 0;
   wb_target_arb_rr #(.N_REQ(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst), .req(req), .cyc(cyc), .tack(tack), .terr(terr),
      .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .to_err(to_err)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset;
      rst = 1'b1;
      tick;
      rst = 1'b0;
   endtask
   initial begin
      #200000;
      $display("FAIL tb_timeout got=running exp=finished");
      $fatal(1);
   end
   initial begin
      rst = 1'b1; req = '0; cyc = '0; tack = 1'b0; terr = 1'b0;
      #12;
      chk("rst_gnt", gnt, 0);
      chk("rst_id", gnt_id, 0);
      chk("rst_valid", gnt_valid, 0);
      chk("rst_toerr", to_err, 0);
      rst = 1'b0; req = 4'b0101; cyc = 4'b0101;
      tick;
      chk("s1_gnt", gnt, 4'b0001);
      chk("s1_id", gnt_id, 0);
      chk("s1_valid", gnt_valid, 1);
      req = 4'b0100;
      tick;
      chk("s1_lock_a", gnt, 4'b0001);
      tick;
      chk("s1_lock_b", gnt, 4'b0001);
      cyc = 4'b0100;
      tick;
      chk("s1_next_gnt", gnt, 4'b0100);
      chk("s1_next_id", gnt_id, 2);
      chk("s1_next_valid", gnt_valid, 1);
      req = '0; cyc = '0;
      tick;
      chk("s1_idle", gnt, 0);
      chk("s1_idle_valid", gnt_valid, 0);
      do_reset;
      req = 4'hf; cyc = 4'hf;
      tick;
      for (int i = 0; i < 5; i++) begin
         oh = 4'b0001 << (i % 4);
         for (int c = 0; c < 3; c++) begin
            chk("s2_gnt", gnt, oh);
            chk("s2_id", gnt_id, i % 4);
            chk("s2_valid", gnt_valid, 1);
            if (c < 2) tick;
         end
         req = 4'hf & ~oh; cyc = 4'hf & ~oh;
         tick;
         req = 4'hf; cyc = 4'hf;
      end
      req = '0; cyc = '0;
      tick;
      tick;
      chk("s2_idle", gnt, 0);
      do_reset;
      req = 4'b0100; cyc = 4'b0100;
      tick;
      for (int k = 1; k <= 20; k++) begin
         #1;
         chk("s3_toerr", to_err, (k == 8 || k == 16));
         chk("s3_gnt", gnt, 4'b0100);
         tick;
      end
      req = '0; cyc = '0;
      #1;
      chk("s3_rel_toerr", to_err, 0);
      tick;
      chk("s3_rel_gnt", gnt, 0);
      do_reset;
      req = 4'b0010; cyc = 4'b0010;
      tick;
      for (int k = 1; k <= 16; k++) begin
         tack = (k == 8);
         #1;
         chk("s4_toerr", to_err, (k == 16));
         chk("s4_gnt", gnt, 4'b0010);
         if (k < 16) tick;
      end
      tack = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      chk("s5_gnt", gnt, 0);
      chk("s5_valid", gnt_valid, 0);
      chk("s5_toerr", to_err, 0);
      chk("s5_id", gnt_id, 0);
      rst = 1'b0; req = 4'b1010; cyc = 4'b1010;
      tick;
      chk("s5_post_gnt", gnt, 4'b0010);
      chk("s5_post_id", gnt_id, 1);
      req = '0; cyc = '0;
      tick;
      tick;
      for (int r = 0; r < 3; r++) begin
         req = 4'b1000; cyc = 4'b1000;
         #1;
         chk("s6_idle_gnt", gnt, 0);
         chk("s6_idle_valid", gnt_valid, 0);
         tick;
         chk("s6_gnt", gnt, 4'b1000);
         chk("s6_id", gnt_id, 3);
         chk("s6_valid", gnt_valid, 1);
         req = '0; cyc = '0;
         tick;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
